matrix_multiplication: RTL and testbench
========================================

# matrix_multiplication

Clocked 4×4 integer matrix multiplier that computes C = A × B. Both operand matrices arrive one after another on a single 256-bit input bus, and the product is returned packed on a 256-bit output bus. It sits as a compute engine behind a bus master that streams packed matrices and collects the packed result.

## Interface
Parameters: none. Element width is fixed at 16 bits and matrix size is fixed at 4×4.

Packing rule (applies to every 256-bit bus): element [row][col] occupies bits `(row*4+col)*16 +: 16`. Storage is row-major, with element [0][0] in bits 15:0.

- `clk` input 1: single clock; all state updates on the rising edge.
- `slapOff` input 1: asynchronous, active-high reset.
- `inValid` input 1: `dataInBus` carries a matrix beat this cycle.
- `dataInBus` input 256: packed matrix beat; first accepted beat = A, second = B.
- `inReady` output 1: high when a beat can be accepted (states IDLE and LOAD_B).
- `dataOut` output 256: packed product C; holds its value until the next result is published.
- `outValid` output 1: one-cycle pulse when `dataOut` is updated.

## Operation
- States:
  - IDLE: waiting for A.
  - LOAD_B: A captured, waiting for B.
  - COMPUTE: 16 cycles.
  - DONE: 1 cycle.
- IDLE: if `inValid`, capture `dataInBus` as A and go to LOAD_B.
- LOAD_B: if `inValid`, capture `dataInBus` as B, clear index k to 0, and go to COMPUTE. Without `inValid`, wait indefinitely.
- COMPUTE: each cycle computes element k, with row = k/4 and col = k%4:
  - C[row][col] = Σ_{n=0..3} A[row][n]·B[n][col]
  - Four 16×16 multipliers run in parallel.
  - Result goes to an internal buffer; k increments. After k = 15 is written, go to DONE.
- DONE: copy the buffer to `dataOut`, pulse `outValid`, return to IDLE.
- Arithmetic:
  - Operands are unsigned 16-bit.
  - Products are 32-bit; the sum uses ≥34 bits internally.
  - The stored element is the sum truncated to bits 15:0 (modulo 2^16). There is no saturation and no overflow flag.
- `inValid` outside IDLE/LOAD_B is ignored; no beat is consumed.
- A and B registers keep their contents until overwritten by the next accepted beats.

## Timing
- Reset (async assert): state = IDLE, `dataOut` = 0, `outValid` = 0, A/B/buffer = 0, k = 0.
- Reset release is synchronous to `clk`.
- `inReady` is combinational from the state: 1 in IDLE/LOAD_B, 0 otherwise. After reset it is 1.
- Back-to-back beats are allowed: A at edge N, B at edge N+1.
- Edges are numbered from the edge E that accepts B:
  - COMPUTE occupies edges E+1..E+16.
  - DONE is the state after E+16.
  - `dataOut` updates and `outValid` goes to 1 at edge E+17.
  - `outValid` returns to 0 at edge E+18.
  - Latency from the B beat to the result is 17 cycles.
- The next A can be accepted at edge E+18 (first IDLE cycle). The minimum period between results is 19 cycles.
- Reset mid-operation (any state) aborts: partial results are discarded and `dataOut` returns to 0.
- `dataOut` never shows partially computed matrices; it changes only at the DONE edge or on reset.

## Test plan
- Nominal product: A rows {5,8,9,2},{7,3,8,4},{6,5,4,3},{8,5,7,6}; B rows {11,14,19,18},{6,9,3,5},{12,10,15,14},{1,3,5,7}; beats on consecutive cycles → `dataOut` rows {213,238,264,270},{195,217,282,281},{147,178,204,210},{208,245,302,309}. `outValid` pulses exactly once, 17 cycles after B.
- Identity: A = identity, B = nominal B above → `dataOut` = B exactly. Then A = nominal, B = identity → `dataOut` = nominal A.
- Overflow wrap: all elements of A and B = 0xFFFF → every C element = 0x0004.
- Gaps and ignored input: hold `inValid` low 5 cycles between A and B → same nominal result. Assert `inValid` throughout COMPUTE/DONE with garbage data → result unchanged, `inReady` = 0 during those cycles, and no extra beat is consumed.
- Reset mid-compute: assert `slapOff` at COMPUTE k = 7 → `dataOut` = 0 and `outValid` = 0 immediately, state IDLE. A fresh A/B pair then yields the correct product.
- Result hold: after the nominal result, load a new A only → `dataOut` still holds the previous result and `outValid` stays 0 until the next DONE.

Source files
------------

// File: rtl/matrix_multiplication.sv
// 4x4 unsigned 16-bit matrix multiplier: C = A x B, operands streamed as two packed beats.
// One output element per cycle from four parallel multipliers; result published in one update.
module matrix_multiplication (
  input  logic         clk,
  input  logic         slapOff,
  input  logic         inValid,
  input  logic [255:0] dataInBus,
  output logic         inReady,
  output logic [255:0] dataOut,
  output logic         outValid
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_B  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [255:0] r_a;
  logic [255:0] r_b;
  logic [255:0] r_buf;
  logic [255:0] r_data_out;
  logic [3:0]   r_k;
  logic         r_out_valid;

  logic [1:0]   w_row;
  logic [1:0]   w_col;
  logic [31:0]  w_prod [4];
  logic [33:0]  w_sum;

  assign w_row = r_k[3:2];
  assign w_col = r_k[1:0];

  // Term n of the dot product: A[row][n] * B[n][col]; bit offset is (idx*16).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mul
      logic [15:0] w_a_el;
      logic [15:0] w_b_el;
      assign w_a_el     = r_a[{w_row, 2'(gi), 4'b0000} +: 16];
      assign w_b_el     = r_b[{2'(gi), w_col, 4'b0000} +: 16];
      assign w_prod[gi] = {16'd0, w_a_el} * {16'd0, w_b_el};
    end
  endgenerate

  assign w_sum = {2'b00, w_prod[0]} + {2'b00, w_prod[1]}
               + {2'b00, w_prod[2]} + {2'b00, w_prod[3]};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (inValid) w_state_next = LOAD_B;
      LOAD_B:  if (inValid) w_state_next = COMPUTE;
      COMPUTE: if (r_k == 4'd15) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge slapOff) begin
    if (slapOff) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_buf       <= '0;
      r_data_out  <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (inValid) r_a <= dataInBus;
        end
        LOAD_B: begin
          if (inValid) begin
            r_b <= dataInBus;
            r_k <= '0;
          end
        end
        COMPUTE: begin
          // Only the low 16 bits of the sum are kept (modulo 2^16).
          r_buf[{r_k, 4'b0000} +: 16] <= w_sum[15:0];
          r_k                         <= r_k + 4'd1;
        end
        DONE: begin
          r_data_out  <= r_buf;
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign inReady  = (r_state == IDLE) || (r_state == LOAD_B);
  assign dataOut  = r_data_out;
  assign outValid = r_out_valid;

endmodule

// File: tb/tb_matrix_multiplication.sv
// Scoreboard bench for matrix_multiplication: stimulus pushes expected products,
// a negedge monitor pops and compares whenever outValid is seen.
module tb_matrix_multiplication;

  logic         clk = 1'b0;
  logic         slapOff;
  logic         inValid;
  logic [255:0] dataInBus;
  logic         inReady;
  logic [255:0] dataOut;
  logic         outValid;

  matrix_multiplication dut (
    .clk       (clk),
    .slapOff   (slapOff),
    .inValid   (inValid),
    .dataInBus (dataInBus),
    .inReady   (inReady),
    .dataOut   (dataOut),
    .outValid  (outValid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  logic [255:0] exp_q [$];
  int           lat_q [$];
  logic [255:0] last_out = '0;
  logic [255:0] mon_exp;
  int           mon_lat;

  int nom_a [16] = '{5,8,9,2, 7,3,8,4, 6,5,4,3, 8,5,7,6};
  int nom_b [16] = '{11,14,19,18, 6,9,3,5, 12,10,15,14, 1,3,5,7};
  int nom_c [16] = '{213,238,264,270, 195,217,282,281, 147,178,204,210, 208,245,302,309};
  int ident [16] = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};

  logic [255:0] NA, NB, NC, ID, ALL1, WRAP;

  function automatic logic [255:0] pack(input int v [16]);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[i*16 +: 16] = v[i][15:0];
    return m;
  endfunction

  // Reference: textbook triple loop with wide integer accumulation, then mod 2^16.
  function automatic logic [255:0] mat_mul(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] c;
    c = '0;
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 4; col++) begin
        longint unsigned s;
        s = 0;
        for (int n = 0; n < 4; n++)
          s += longint'(a[(r*4+n)*16 +: 16]) * longint'(b[(n*4+col)*16 +: 16]);
        c[(r*4+col)*16 +: 16] = s[15:0];
      end
    end
    return c;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every outValid must match the oldest expected result and arrive 17 cycles after B.
  always @(negedge clk) begin
    if (slapOff) begin
      last_out = dataOut;
    end else begin
      if (outValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_outValid: got outValid=1 data %h expected no result pending", dataOut);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_lat = lat_q.pop_front();
          check_vec("result", dataOut, mon_exp);
          check_int("latency", cyc - mon_lat, 17);
        end
      end else if (dataOut !== last_out) begin
        checks++;
        errors++;
        $display("FAIL dataOut_hold: got %h expected %h (changed without outValid)", dataOut, last_out);
      end
      last_out = dataOut;
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send_beat(input logic [255:0] m);
    int t = 0;
    while (inReady !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (inReady !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL inReady_timeout: got inReady=%b expected 1 within 100 cycles", inReady);
    end
    inValid   = 1'b1;
    dataInBus = m;
    @(negedge clk);
    inValid   = 1'b0;
    dataInBus = rnd256();
  endtask

  task automatic send_pair(input logic [255:0] a, input logic [255:0] b,
                           input logic [255:0] exp, input int gap, input bit garbage);
    send_beat(a);
    repeat (gap) @(negedge clk);
    send_beat(b);
    exp_q.push_back(exp);
    lat_q.push_back(cyc);
    if (garbage) begin
      for (int i = 0; i < 17; i++) begin
        check_int("inReady_busy", int'(inReady), 0);
        inValid   = 1'b1;
        dataInBus = rnd256();
        @(negedge clk);
      end
      inValid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: got %0d results pending expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] a2, b2, ra, rb;
    NA   = pack(nom_a);
    NB   = pack(nom_b);
    NC   = pack(nom_c);
    ID   = pack(ident);
    ALL1 = {256{1'b1}};
    WRAP = {16{16'h0004}};

    slapOff   = 1'b1;
    inValid   = 1'b0;
    dataInBus = '0;
    #12;
    check_vec("reset_dataOut", dataOut, '0);
    check_int("reset_outValid", int'(outValid), 0);
    check_int("reset_inReady", int'(inReady), 1);
    @(negedge clk);
    #1 slapOff = 1'b0;
    @(negedge clk);

    send_pair(NA, NB, NC, 0, 1'b0);
    wait_idle();
    send_pair(ID, NB, NB, 0, 1'b0);
    send_pair(NA, ID, NA, 0, 1'b0);
    send_pair(ALL1, ALL1, WRAP, 0, 1'b0);
    send_pair(NA, NB, NC, 5, 1'b0);
    wait_idle();

    // Garbage held on inValid through COMPUTE/DONE, then an immediate follow-on pair.
    send_pair(NA, NB, NC, 0, 1'b1);
    ra = rnd256();
    rb = rnd256();
    send_pair(ra, rb, mat_mul(ra, rb), 0, 1'b0);
    wait_idle();

    // Reset while k = 7 is the next element to compute.
    send_beat(rnd256());
    send_beat(rnd256());
    repeat (7) @(negedge clk);
    #1 slapOff = 1'b1;
    #1;
    check_vec("midreset_dataOut", dataOut, '0);
    check_int("midreset_outValid", int'(outValid), 0);
    check_int("midreset_inReady", int'(inReady), 1);
    @(negedge clk);
    #1 slapOff = 1'b0;
    @(negedge clk);
    send_pair(NA, NB, NC, 0, 1'b0);
    wait_idle();

    // Only a new A: the previous result must stay on dataOut.
    a2 = rnd256();
    b2 = rnd256();
    send_beat(a2);
    repeat (10) @(negedge clk);
    check_vec("hold_dataOut", dataOut, NC);
    check_int("hold_outValid", int'(outValid), 0);
    send_beat(b2);
    exp_q.push_back(mat_mul(a2, b2));
    lat_q.push_back(cyc);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      ra = rnd256();
      rb = rnd256();
      send_pair(ra, rb, mat_mul(ra, rb), int'($urandom_range(0, 3)), 1'b0);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
